// File: rtl/dht_pkg.sv
// rtl/dht_pkg.sv - shared command, status and state encodings for the DHT channel controller
package dht_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_WAIT  = 3'd2,
      S_LATCH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [7:0] CMD_HEALTH = 8'h01;
   localparam logic [7:0] CMD_TEMP   = 8'h02;
   localparam logic [7:0] CMD_HUM    = 8'h03;

   localparam logic [7:0] ST_OK      = 8'h00;
   localparam logic [7:0] ST_SENSOR  = 8'h1F;
   localparam logic [7:0] ST_TIMEOUT = 8'h1E;
   localparam logic [7:0] ST_CRC     = 8'h1D;
   localparam logic [7:0] ST_BADCMD  = 8'hEF;
   localparam logic [7:0] ST_BADADDR = 8'hEE;

   function automatic logic cmd_valid(input logic [7:0] cmd);
      return (cmd == CMD_HEALTH) || (cmd == CMD_TEMP) || (cmd == CMD_HUM);
   endfunction

   // Frame layout {HumInt,HumFloat,TempInt,TempFloat,Crc}; checksum wraps at 8 bits
   function automatic logic [7:0] frame_sum(input logic [39:0] frame);
      logic [7:0] s;
      s = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
      return s;
   endfunction

endpackage

// File: rtl/dht_multi_interface_if.sv
// rtl/dht_multi_interface_if.sv - host-side request/response bundle of the DHT channel controller
interface dht_multi_interface_if #(
   parameter int CH_W = 2
);
   logic            i_En;
   logic [CH_W-1:0] i_Addr;
   logic [7:0]      i_request;
   logic [7:0]      o_data_int;
   logic [7:0]      o_data_float;
   logic [7:0]      o_status;
   logic            o_done;
   logic            o_busy;

   modport master (
      output i_En, i_Addr, i_request,
      input  o_data_int, o_data_float, o_status, o_done, o_busy
   );

   modport slave (
      input  i_En, i_Addr, i_request,
      output o_data_int, o_data_float, o_status, o_done, o_busy
   );
endinterface

// File: rtl/dht_timeout_cnt.sv
// rtl/dht_timeout_cnt.sv - per-read watchdog counter with clear, enable and expire
module dht_timeout_cnt #(
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic i_Clock,
   input  logic i_Rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] count;

   // Count while enabled, parking on the last value so expire stays asserted
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         count <= '0;
      end else if (i_clear) begin
         count <= '0;
      end else if (i_enable && (count != LAST)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign o_expire = (count == LAST);
endmodule

// File: rtl/dht_multi_interface.sv
// rtl/dht_multi_interface.sv - multiplexes one host request onto N_CH DHT sensor drivers
module dht_multi_interface
   import dht_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int CH_W        = 2,
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic                i_Clock,
   input  logic                i_Rst_n,
   dht_multi_interface_if.slave host,
   output logic [N_CH-1:0]     o_Dht_En,
   output logic [N_CH-1:0]     o_Dht_Rst,
   input  logic [N_CH-1:0]     i_Dht_Done,
   input  logic [N_CH-1:0]     i_Dht_Error,
   input  logic [40*N_CH-1:0]  i_Dht_Data
);
   state_t          state;
   logic [CH_W-1:0] addr_q;
   logic [7:0]      req_q;
   logic [7:0]      data_int_q;
   logic [7:0]      data_float_q;
   logic [7:0]      status_q;
   logic            done_q;

   logic            sel_done;
   logic            sel_err;
   logic [39:0]     sel_frame;
   logic [N_CH-1:0] addr_onehot;
   logic            addr_ok;
   logic            expire;

   assign addr_ok = (32'(host.i_Addr) < 32'(N_CH));

   // Select the addressed channel's flags and frame; other channels are ignored
   always_comb begin
      sel_done    = 1'b0;
      sel_err     = 1'b0;
      sel_frame   = '0;
      addr_onehot = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (addr_q == CH_W'(k)) begin
            sel_done       = i_Dht_Done[k];
            sel_err        = i_Dht_Error[k];
            sel_frame      = i_Dht_Data[40*k +: 40];
            addr_onehot[k] = 1'b1;
         end
      end
   end

   dht_timeout_cnt #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timeout (
      .i_Clock (i_Clock),
      .i_Rst_n (i_Rst_n),
      .i_clear (state == S_ARM),
      .i_enable(state == S_WAIT),
      .o_expire(expire)
   );

   // Transaction FSM; every exit into DONE loads status/strobes on the same edge
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state        <= S_IDLE;
         addr_q       <= '0;
         req_q        <= '0;
         o_Dht_En     <= '0;
         o_Dht_Rst    <= '0;
         data_int_q   <= '0;
         data_float_q <= '0;
         status_q     <= ST_OK;
         done_q       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (host.i_En) begin
                  addr_q <= host.i_Addr;
                  req_q  <= host.i_request;
                  if (!cmd_valid(host.i_request)) begin
                     status_q <= ST_BADCMD;
                     done_q   <= 1'b1;
                     state    <= S_DONE;
                  end else if (!addr_ok) begin
                     status_q <= ST_BADADDR;
                     done_q   <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     state <= S_ARM;
                  end
               end
            end
            S_ARM: begin
               o_Dht_En <= addr_onehot;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (sel_err || (!sel_done && expire)) begin
                  status_q  <= sel_err ? ST_SENSOR : ST_TIMEOUT;
                  o_Dht_En  <= '0;
                  o_Dht_Rst <= addr_onehot;
                  done_q    <= 1'b1;
                  state     <= S_DONE;
               end else if (sel_done) begin
                  state <= S_LATCH;
               end
            end
            S_LATCH: begin
               if (frame_sum(sel_frame) != sel_frame[7:0]) begin
                  status_q <= ST_CRC;
               end else begin
                  status_q <= ST_OK;
                  case (req_q)
                     CMD_TEMP: begin
                        data_int_q   <= sel_frame[23:16];
                        data_float_q <= sel_frame[15:8];
                     end
                     CMD_HUM: begin
                        data_int_q   <= sel_frame[39:32];
                        data_float_q <= sel_frame[31:24];
                     end
                     default: begin
                        data_int_q   <= 8'h00;
                        data_float_q <= 8'h00;
                     end
                  endcase
               end
               o_Dht_En  <= '0;
               o_Dht_Rst <= addr_onehot;
               done_q    <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               done_q    <= 1'b0;
               o_Dht_Rst <= '0;
               o_Dht_En  <= '0;
               state     <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign host.o_data_int   = data_int_q;
   assign host.o_data_float = data_float_q;
   assign host.o_status     = status_q;
   assign host.o_done       = done_q;
   assign host.o_busy       = (state != S_IDLE);
endmodule

// File: tb/tb_dht_multi_interface.sv
// tb/tb_dht_multi_interface.sv - directed vector bench for dht_multi_interface
module tb_dht_multi_interface;
   localparam int N_CH = 4;
   localparam int CH_W = 3;
   localparam int TO   = 100;

   localparam int M_DONE  = 0;
   localparam int M_ERR   = 1;
   localparam int M_BOTH  = 2;
   localparam int M_NONE  = 3;
   localparam int M_OTHER = 4;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [N_CH-1:0]     dht_en;
   logic [N_CH-1:0]     dht_rst;
   logic [N_CH-1:0]     dht_done;
   logic [N_CH-1:0]     dht_error;
   logic [40*N_CH-1:0]  dht_data;

   always #5 clk = ~clk;

   dht_multi_interface_if #(.CH_W(CH_W)) host();

   dht_multi_interface #(
      .N_CH(N_CH), .CH_W(CH_W), .TIMEOUT_CYC(TO)
   ) dut (
      .i_Clock    (clk),
      .i_Rst_n    (rst_n),
      .host       (host.slave),
      .o_Dht_En   (dht_en),
      .o_Dht_Rst  (dht_rst),
      .i_Dht_Done (dht_done),
      .i_Dht_Error(dht_error),
      .i_Dht_Data (dht_data)
   );

   typedef struct {
      logic [2:0]  addr;
      logic [7:0]  req;
      logic [39:0] frame;
      int          mode;
      logic [7:0]  st;
      logic [7:0]  di;
      logic [7:0]  df;
      int          lat;
      bit          armed;
   } vec_t;

   vec_t vecs[12];
   int   n_vec = 0;
   int   misc  = 0;
   int   n_chk = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         misc++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_txn(input logic [2:0] a, input logic [7:0] r, input logic [39:0] frame,
                          input int mode, output int lat, output bit en_seen,
                          output logic [N_CH-1:0] rst_at_done, output logic done_after);
      int stage;
      bit got;
      @(negedge clk);
      for (int k = 0; k < N_CH; k++)
         dht_data[40*k +: 40] = (k == int'(a)) ? frame : 40'hAA_BB_CC_DD_EE;
      host.i_En      = 1'b1;
      host.i_Addr    = a;
      host.i_request = r;
      lat = 0; en_seen = 0; rst_at_done = '0; stage = 0; got = 0;
      for (int n = 1; n <= 300 && !got; n++) begin
         @(posedge clk); #1;
         host.i_En = 1'b0;
         dht_done  = '0;
         dht_error = '0;
         if (dht_en != '0) en_seen = 1;
         if (host.o_done) begin
            got = 1;
            lat = n;
            rst_at_done = dht_rst;
         end else if (en_seen) begin
            if (stage == 0) begin
               case (mode)
                  M_DONE:  dht_done[a[1:0]] = 1'b1;
                  M_ERR:   dht_error[a[1:0]] = 1'b1;
                  M_BOTH:  begin dht_done[a[1:0]] = 1'b1; dht_error[a[1:0]] = 1'b1; end
                  M_OTHER: dht_done[a[1:0] + 2'd1] = 1'b1;
                  default: ;
               endcase
            end else if (stage == 1 && mode == M_OTHER) begin
               dht_done[a[1:0]] = 1'b1;
            end
            stage++;
         end
      end
      @(posedge clk); #1;
      done_after = host.o_done;
   endtask

   initial begin
      int          lat;
      bit          en_seen;
      logic [N_CH-1:0] rst_d;
      logic        done_after;
      bit          seen;
      string       tag;

      host.i_En = 1'b0; host.i_Addr = '0; host.i_request = '0;
      dht_done = '0; dht_error = '0; dht_data = '0;

      vecs[0]  = '{3'd2, 8'h02, 40'h37_00_19_05_55, M_DONE,  8'h00, 8'h19, 8'h05, 4,   1'b1};
      vecs[1]  = '{3'd1, 8'h03, 40'h37_00_19_05_00, M_DONE,  8'h1D, 8'h19, 8'h05, 4,   1'b1};
      vecs[2]  = '{3'd0, 8'h03, 40'h40_08_1A_02_64, M_DONE,  8'h00, 8'h40, 8'h08, 4,   1'b1};
      vecs[3]  = '{3'd3, 8'h01, 40'h11_22_33_44_AA, M_DONE,  8'h00, 8'h00, 8'h00, 4,   1'b1};
      vecs[4]  = '{3'd1, 8'h07, 40'h11_22_33_44_AA, M_DONE,  8'hEF, 8'h00, 8'h00, 1,   1'b0};
      vecs[5]  = '{3'd4, 8'h02, 40'h11_22_33_44_AA, M_DONE,  8'hEE, 8'h00, 8'h00, 1,   1'b0};
      vecs[6]  = '{3'd5, 8'h09, 40'h11_22_33_44_AA, M_DONE,  8'hEF, 8'h00, 8'h00, 1,   1'b0};
      vecs[7]  = '{3'd2, 8'h02, 40'h37_00_19_05_55, M_BOTH,  8'h1F, 8'h00, 8'h00, 3,   1'b1};
      vecs[8]  = '{3'd0, 8'h02, 40'h37_00_19_05_55, M_ERR,   8'h1F, 8'h00, 8'h00, 3,   1'b1};
      vecs[9]  = '{3'd1, 8'h02, 40'h10_00_20_03_33, M_OTHER, 8'h00, 8'h20, 8'h03, 5,   1'b1};
      vecs[10] = '{3'd3, 8'h03, 40'h10_00_20_03_33, M_NONE,  8'h1E, 8'h20, 8'h03, 102, 1'b1};
      vecs[11] = '{3'd2, 8'h02, 40'hFF_01_80_7F_FF, M_DONE,  8'h00, 8'h80, 8'h7F, 4,   1'b1};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_status", host.o_status, 8'h00);
      chk("reset_busy",   host.o_busy,   1'b0);
      chk("reset_done",   host.o_done,   1'b0);
      chk("reset_dht_en", dht_en,        '0);
      chk("reset_dht_rst", dht_rst,      '0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_txn(vecs[i].addr, vecs[i].req, vecs[i].frame, vecs[i].mode,
                 lat, en_seen, rst_d, done_after);
         n_vec++;
         tag = $sformatf("v%0d", i);
         chk({tag, "_status"},  host.o_status,     vecs[i].st);
         chk({tag, "_int"},     host.o_data_int,   vecs[i].di);
         chk({tag, "_float"},   host.o_data_float, vecs[i].df);
         chk({tag, "_latency"}, lat,               vecs[i].lat);
         chk({tag, "_armed"},   en_seen,           vecs[i].armed);
         chk({tag, "_dht_rst"}, rst_d,
             vecs[i].armed ? (4'b0001 << vecs[i].addr[1:0]) : 4'b0000);
         chk({tag, "_done_1cyc"}, done_after,      1'b0);
      end

      // Reset asserted while the channel is armed and waiting
      @(negedge clk);
      dht_data[80 +: 40] = 40'h37_00_19_05_55;
      host.i_En = 1'b1; host.i_Addr = 3'd2; host.i_request = 8'h02;
      @(posedge clk); #1;
      host.i_En = 1'b0;
      seen = 0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(posedge clk); #1;
         if (dht_en != '0) seen = 1;
      end
      chk("rstseq_armed", dht_en, 4'b0100);
      @(posedge clk); #1;
      chk("rstseq_busy_pre", host.o_busy, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstseq_dht_en", dht_en,            '0);
      chk("rstseq_busy",   host.o_busy,       1'b0);
      chk("rstseq_status", host.o_status,     8'h00);
      chk("rstseq_int",    host.o_data_int,   8'h00);
      chk("rstseq_float",  host.o_data_float, 8'h00);
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (host.o_done) seen = 1;
      end
      chk("rstseq_no_done", seen, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      run_txn(3'd2, 8'h02, 40'h37_00_19_05_55, M_DONE, lat, en_seen, rst_d, done_after);
      n_vec++;
      chk("post_rst_status",  host.o_status,     8'h00);
      chk("post_rst_int",     host.o_data_int,   8'h19);
      chk("post_rst_float",   host.o_data_float, 8'h05);
      chk("post_rst_latency", lat,               4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, misc);
      $finish;
   end
endmodule

// File: doc/dht_multi_interface.md
DHT_MULTI_INTERFACE -- requirements
Module: dht_multi_interface

Interface
REQ-001 Parameter N_CH, default 4: number of sensor channels, 1..16.
REQ-002 Parameter CH_W, default 2: channel-address width, with 2**CH_W >= N_CH.
REQ-003 Parameter TIMEOUT_CYC, default 50_000_000: cycles allowed per read before a timeout is declared.
REQ-004 Clock and reset ports: one clock; reset is asynchronous and active-low.
REQ-005 i_Clock  in  1  system clock; all logic on the rising edge.
REQ-006 i_Rst_n  in  1  asynchronous active-low reset.
REQ-007 i_En  in  1  start pulse; sampled only in IDLE.
REQ-008 i_Addr  in  CH_W  target channel, captured with i_En.
REQ-009 i_request  in  8  command code, captured with i_En.
REQ-010 o_Dht_En  out  N_CH  per-channel driver enable, one-hot or zero.
REQ-011 o_Dht_Rst  out  N_CH  per-channel driver reset pulse, active-high.
REQ-012 i_Dht_Done  in  N_CH  per-channel driver frame-complete flag.
REQ-013 i_Dht_Error  in  N_CH  per-channel driver error flag.
REQ-014 i_Dht_Data  in  40*N_CH  per channel {HumInt,HumFloat,TempInt,TempFloat,Crc}; channel k occupies bits [40k+39:40k].
REQ-015 o_data_int  out  8  integer result byte.
REQ-016 o_data_float  out  8  fractional result byte.
REQ-017 o_status  out  8  completion code for the last transaction.
REQ-018 o_done  out  1  one-cycle completion strobe.
REQ-019 o_busy  out  1  high whenever state != IDLE.

Function
REQ-020 The block SHALL implement the states IDLE, ARM, WAIT, LATCH, DONE.
REQ-021 Valid commands: 0x01 health check (data bytes forced to 0x00), 0x02 temperature, 0x03 humidity.
REQ-022 IDLE, on i_En=1: capture i_Addr and i_request; go to ARM if both are valid, otherwise go straight to DONE with o_status=0xEF (bad command) or 0xEE (i_Addr >= N_CH); bad command has priority when both are invalid.
REQ-023 ARM SHALL assert o_Dht_En[addr], clear the timeout counter, and go to WAIT next cycle.
REQ-024 WAIT, evaluated in priority order error > done > timeout: i_Dht_Error[addr] -> status 0x1F; i_Dht_Done[addr] -> LATCH; counter reaching TIMEOUT_CYC-1 -> status 0x1E; the error and timeout exits go to DONE.
REQ-025 LATCH SHALL compute the checksum as the 8-bit wrapping sum of the four data bytes; on mismatch with Crc -> status 0x1D and data unchanged, otherwise status 0x00 and the data bytes per command.
REQ-026 DONE SHALL pulse o_done for exactly one cycle, pulse o_Dht_Rst[addr] in the same cycle (only if the channel was armed), deassert o_Dht_En, and return to IDLE.
REQ-027 Flags on non-addressed channels SHALL be ignored, and i_En outside IDLE SHALL be ignored (no queueing).
REQ-028 o_data_int, o_data_float and o_status SHALL hold their values until the next DONE.
REQ-029 Latency from i_En to o_done for a valid read SHALL be (driver done cycle) + 2 cycles; for a rejected command it SHALL be exactly 1 cycle.

Reset
REQ-030 i_Rst_n=0 SHALL immediately force state to IDLE, o_Dht_En=0, o_Dht_Rst=0, o_done=0, o_busy=0, o_data_int=0x00, o_data_float=0x00, o_status=0x00, and the counter to 0.
REQ-031 Reset mid-transaction SHALL abort it with no o_done strobe; the first i_En after reset release SHALL be accepted.

Structure
REQ-032 A shared package dht_pkg SHALL hold the command codes (CMD_HEALTH, CMD_TEMP, CMD_HUM), the status codes (ST_OK, ST_SENSOR, ST_TIMEOUT, ST_CRC, ST_BADCMD, ST_BADADDR) and the state encoding.
REQ-033 The timeout logic SHALL be a single sub-module, dht_timeout_cnt (clear, enable, expire output); the channel multiplexing SHALL be done inline.

Verification
REQ-034 Scenario: addr=2, req=0x02, channel 2 done with {0x37,0x00,0x19,0x05,0x55} -> o_data_int=0x19, o_data_float=0x05, o_status=0x00, single-cycle o_done.
REQ-035 Scenario: req=0x03, CRC byte 0x00 with a data sum of 0x55 -> o_status=0x1D, data unchanged from the previous transaction.
REQ-036 Scenario: req=0x07 -> o_done exactly 1 cycle after i_En, o_status=0xEF, o_Dht_En never asserted; addr=N_CH with req=0x02 -> o_status=0xEE.
REQ-037 Scenario: TIMEOUT_CYC=100 with no driver response -> o_done 101-102 cycles after i_En, o_status=0x1E, o_Dht_Rst pulsed.
REQ-038 Scenario: error and done asserted in the same cycle -> o_status=0x1F; a done on another channel during WAIT is ignored.
REQ-039 Scenario: i_Rst_n low during WAIT -> all outputs reset, no o_done strobe; a new request after release completes normally.
